// File: rtl/tdp_ram_pkg.sv
// Shared types and helpers for the true dual-port byte-enable RAM.
//   rd_mode_e   : same-port read-during-write behaviour
//   clr_state_e : post-reset clear sequencer states
//   byte_merge  : overlay enabled bytes of a new word onto an old word
package tdp_ram_pkg;

  typedef enum logic {
    READ_FIRST  = 1'b0,
    WRITE_FIRST = 1'b1
  } rd_mode_e;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } clr_state_e;

  // byte_merge works on the widest supported word; callers zero-extend
  // their operands and truncate the result back to their own width.
  localparam int MAX_DW = 256;
  localparam int MAX_NB = MAX_DW / 8;

  function automatic logic [MAX_DW-1:0] byte_merge(
    input logic [MAX_DW-1:0] old_w,
    input logic [MAX_DW-1:0] new_w,
    input logic [MAX_NB-1:0] be
  );
    logic [MAX_DW-1:0] m;
    m = old_w;
    for (int i = 0; i < MAX_NB; i++) begin
      if (be[i]) m[8*i +: 8] = new_w[8*i +: 8];
    end
    return m;
  endfunction

endpackage

// File: rtl/tdp_ram_rd_port.sv
// Per-port read path: selects old or merged word, holds it between
// accesses, flags dvalid for one cycle per access, optional extra stage.
//   clk, rst_n : clock, async active-low reset
//   acc_i      : access accepted this cycle (enable gated by clear FSM)
//   we_i, be_i : write flag and byte enables of the access
//   din_i      : write data of the access
//   old_i      : current array contents at the access address
//   dout_o     : read data
//   dvalid_o   : dout_o updated this cycle
module tdp_ram_rd_port
  import tdp_ram_pkg::*;
#(
  parameter int       D_WIDTH = 32,
  parameter rd_mode_e RD_MODE = READ_FIRST,
  parameter bit       OUT_REG = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 acc_i,
  input  logic                 we_i,
  input  logic [D_WIDTH/8-1:0] be_i,
  input  logic [D_WIDTH-1:0]   din_i,
  input  logic [D_WIDTH-1:0]   old_i,
  output logic [D_WIDTH-1:0]   dout_o,
  output logic                 dvalid_o
);

  logic [D_WIDTH-1:0] rdata_d, rdata_q;
  logic               valid_q;

  always_comb begin
    // NOTE: defaulting to the held value first keeps this purely
    // combinational; any path that skipped an assignment would infer a latch.
    rdata_d = rdata_q;
    if (acc_i) begin
      if (RD_MODE == WRITE_FIRST && we_i) begin
        rdata_d = D_WIDTH'(byte_merge(MAX_DW'(old_i), MAX_DW'(din_i), MAX_NB'(be_i)));
      end else begin
        rdata_d = old_i;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
      valid_q <= 1'b0;
    end else begin
      rdata_q <= rdata_d;
      valid_q <= acc_i;
    end
  end

  generate
    if (OUT_REG) begin : g_out_reg
      logic [D_WIDTH-1:0] dout_q;
      logic               dvalid_q;
      // Stage 1 already holds between accesses, so a free-running copy
      // preserves the hold behaviour one cycle later.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          dout_q   <= '0;
          dvalid_q <= 1'b0;
        end else begin
          dout_q   <= rdata_q;
          dvalid_q <= valid_q;
        end
      end
      assign dout_o   = dout_q;
      assign dvalid_o = dvalid_q;
    end else begin : g_no_out_reg
      assign dout_o   = rdata_q;
      assign dvalid_o = valid_q;
    end
  endgenerate

endmodule

// File: rtl/tdp_ram_be.sv
// True dual-port synchronous RAM with per-byte write enables, port-A
// priority on write collisions, and a post-reset clear sequencer.
//   clk, rst_n          : clock, async active-low reset
//   en_x, we_x          : access request / write select per port
//   be_x, add_x, din_x  : byte enables, address, write data per port
//   dout_x, dvalid_x    : read data and its update strobe per port
//   coll                : both ports wrote overlapping bytes of one address
//   init_busy           : clear sequence running, requests ignored
module tdp_ram_be
  import tdp_ram_pkg::*;
#(
  parameter int       A_WIDTH = 4,
  parameter int       D_WIDTH = 32,
  parameter rd_mode_e RD_MODE = READ_FIRST,
  parameter bit       OUT_REG = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en_a,
  input  logic                 we_a,
  input  logic [D_WIDTH/8-1:0] be_a,
  input  logic [A_WIDTH-1:0]   add_a,
  input  logic [D_WIDTH-1:0]   din_a,
  output logic [D_WIDTH-1:0]   dout_a,
  output logic                 dvalid_a,
  input  logic                 en_b,
  input  logic                 we_b,
  input  logic [D_WIDTH/8-1:0] be_b,
  input  logic [A_WIDTH-1:0]   add_b,
  input  logic [D_WIDTH-1:0]   din_b,
  output logic [D_WIDTH-1:0]   dout_b,
  output logic                 dvalid_b,
  output logic                 coll,
  output logic                 init_busy
);

  localparam int DEPTH = 2 ** A_WIDTH;
  localparam int NB    = D_WIDTH / 8;

  logic [D_WIDTH-1:0] mem_q [DEPTH];

  clr_state_e         state_q, state_d;
  logic [A_WIDTH-1:0] clr_ptr_q, clr_ptr_d;
  logic               coll_q, coll_d;

  logic               acc_a, acc_b;
  logic [NB-1:0]      wr_be_a, wr_be_b_raw, wr_be_b;

  // ---------------- clear sequencer ----------------
  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    case (state_q)
      CLEAR: begin
        clr_ptr_d = clr_ptr_q + A_WIDTH'(1);
        if (clr_ptr_q == A_WIDTH'(DEPTH - 1)) state_d = READY;
      end
      READY: ;
      default: state_d = CLEAR;
    endcase
  end

  assign init_busy = (state_q == CLEAR);
  assign acc_a     = en_a && !init_busy;
  assign acc_b     = en_b && !init_busy;

  // ---------------- write masks and collision ----------------
  assign wr_be_a     = (acc_a && we_a) ? be_a : '0;
  assign wr_be_b_raw = (acc_b && we_b) ? be_b : '0;
  // Port A owns every byte it enables on a shared address; B keeps the rest.
  assign wr_be_b     = (add_a == add_b) ? (wr_be_b_raw & ~wr_be_a) : wr_be_b_raw;
  assign coll_d      = (add_a == add_b) && |(wr_be_a & wr_be_b_raw);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= CLEAR;
      clr_ptr_q <= '0;
      coll_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_ptr_q <= clr_ptr_d;
      coll_q    <= coll_d;
    end
  end

  assign coll = coll_q;

  // ---------------- storage ----------------
  // NOTE: the array has no reset so it maps onto block RAM; the clear
  // sequencer provides the known contents instead.
  always_ff @(posedge clk) begin
    if (state_q == CLEAR) begin
      mem_q[clr_ptr_q] <= '0;
    end else begin
      for (int i = 0; i < NB; i++) begin
        if (wr_be_a[i]) mem_q[add_a][8*i +: 8] <= din_a[8*i +: 8];
        if (wr_be_b[i]) mem_q[add_b][8*i +: 8] <= din_b[8*i +: 8];
      end
    end
  end

  // ---------------- read paths ----------------
  tdp_ram_rd_port #(.D_WIDTH(D_WIDTH), .RD_MODE(RD_MODE), .OUT_REG(OUT_REG)) u_rd_a (
    .clk      (clk),
    .rst_n    (rst_n),
    .acc_i    (acc_a),
    .we_i     (we_a),
    .be_i     (be_a),
    .din_i    (din_a),
    .old_i    (mem_q[add_a]),
    .dout_o   (dout_a),
    .dvalid_o (dvalid_a)
  );

  tdp_ram_rd_port #(.D_WIDTH(D_WIDTH), .RD_MODE(RD_MODE), .OUT_REG(OUT_REG)) u_rd_b (
    .clk      (clk),
    .rst_n    (rst_n),
    .acc_i    (acc_b),
    .we_i     (we_b),
    .be_i     (be_b),
    .din_i    (din_b),
    .old_i    (mem_q[add_b]),
    .dout_o   (dout_b),
    .dvalid_o (dvalid_b)
  );

endmodule
